pwm_cfg_spi: RTL

PWM_CFG_SPI -- requirements
Module: pwm_cfg_spi

---
 rtl/pwm_cfg_pkg.sv | 44 ++++
 rtl/pwm_cfg_spi_if.sv | 21 ++
 rtl/sync_edge.sv | 33 +++
 rtl/pwm_cfg_spi.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pwm_cfg_pkg.sv
// Shared constants, FSM state type and register-map helpers for the
// PWM configuration SPI slave.
package pwm_cfg_pkg;

    localparam logic [3:0] ADDR_DUTY = 4'd0;
    localparam logic [3:0] ADDR_MAX  = 4'd1;
    localparam logic [3:0] ADDR_ID   = 4'd2;
    localparam logic [3:0] ADDR_STAT = 4'd3;

    localparam logic [7:0] ID_VALUE  = 8'hA5;
    localparam logic [7:0] DUTY_RST  = 8'h00;
    localparam logic [7:0] MAX_RST   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_e;

    function automatic logic [7:0] read_mux(
        input logic [3:0] addr,
        input logic [7:0] duty_sh,
        input logic [7:0] max_sh,
        input logic       pending,
        input logic       err_flag
    );
        logic [7:0] v;
        case (addr)
            ADDR_DUTY: v = duty_sh;
            ADDR_MAX:  v = max_sh;
            ADDR_ID:   v = ID_VALUE;
            ADDR_STAT: v = {6'b000000, pending, err_flag};
            default:   v = 8'h00;
        endcase
        return v;
    endfunction

    // The ID register and the unmapped space reject writes.
    function automatic logic addr_wr_illegal(input logic [3:0] addr);
        return (addr == ADDR_ID) || (addr > ADDR_STAT);
    endfunction

endpackage

// File: rtl/pwm_cfg_spi_if.sv
// SPI bus between the Arduino master and the PWM configuration slave.
interface pwm_cfg_spi_if;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_cs_n;
    logic spi_miso;

    modport master (
        output spi_sclk,
        output spi_mosi,
        output spi_cs_n,
        input  spi_miso
    );

    modport slave (
        input  spi_sclk,
        input  spi_mosi,
        input  spi_cs_n,
        output spi_miso
    );
endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall pulses
// derived in the clk domain.
module sync_edge #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{IDLE_LVL}};
            r_prev <= IDLE_LVL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/pwm_cfg_spi.sv
// SPI mode-0 configuration slave for a PWM: shadowed duty/period registers
// that commit together only on the PWM period boundary.
module pwm_cfg_spi
    import pwm_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_cfg_spi_if.slave spi,
    input  logic         period_end,
    output logic [7:0]   duty,
    output logic [7:0]   max_value,
    output logic         cfg_valid,
    output logic         err
);

    logic       w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic       w_mosi_level, w_mosi_rise, w_mosi_fall;
    logic       w_cs_level, w_cs_rise, w_cs_fall;
    logic       w_unused;

    state_e     r_state, w_state_next;
    logic [3:0] r_bit_cnt, w_cnt_next;
    logic [6:0] r_shift;
    logic [7:0] w_byte;
    logic       w_cmd_done, w_frame_done;
    logic       r_rw;
    logic [3:0] r_addr;
    logic [7:0] r_tx;
    logic       r_miso;

    logic [7:0] r_duty_sh, r_max_sh, r_duty, r_max;
    logic       r_pending, r_cfg_valid, r_err;
    logic       w_wr_en, w_wr_duty, w_wr_max, w_err_set, w_err_clr, w_commit;

    sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(spi.spi_sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_async(spi.spi_mosi),
        .o_level(w_mosi_level), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_async(spi.spi_cs_n),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    assign w_unused = ^{w_sclk_level, w_mosi_rise, w_mosi_fall};
    assign w_byte   = {r_shift, w_mosi_level};

    // Frame sequencing: next state, bit count and end-of-byte strobes
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_bit_cnt;
        w_cmd_done   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = 4'd0;
                if (w_cs_fall) w_state_next = CMD;
                else           w_state_next = IDLE;
            end
            CMD: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 4'd0;
                end else if (w_sclk_rise) begin
                    w_cnt_next = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_cmd_done   = 1'b1;
                        w_state_next = DATA;
                    end else begin
                        w_state_next = CMD;
                    end
                end else begin
                    w_state_next = CMD;
                end
            end
            DATA: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 4'd0;
                end else if (w_sclk_rise) begin
                    if (r_bit_cnt == 4'd15) begin
                        w_frame_done = 1'b1;
                        w_state_next = HOLD;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_state_next = DATA;
                        w_cnt_next   = r_bit_cnt + 4'd1;
                    end
                end else begin
                    w_state_next = DATA;
                end
            end
            HOLD: begin
                w_cnt_next = 4'd0;
                if (w_cs_level) w_state_next = IDLE;
                else            w_state_next = HOLD;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Frame state, receive shifter, read-data latch and miso driver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 7'd0;
            r_rw      <= 1'b0;
            r_addr    <= 4'd0;
            r_tx      <= 8'h00;
            r_miso    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_cnt_next;
            if (w_sclk_rise && (r_state == CMD || r_state == DATA)) r_shift <= w_byte[6:0];
            if (w_cmd_done) begin
                r_rw   <= w_byte[7];
                r_addr <= w_byte[3:0];
                r_tx   <= read_mux(w_byte[3:0], r_duty_sh, r_max_sh, r_pending, r_err);
            end else if (r_state == DATA && w_sclk_fall) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end
            // miso only carries read data during DATA; everywhere else it idles low
            if (r_state != DATA)           r_miso <= 1'b0;
            else if (w_sclk_fall && !r_rw) r_miso <= r_tx[7];
        end
    end

    assign w_wr_en   = w_frame_done & r_rw;
    assign w_wr_duty = w_wr_en & (r_addr == ADDR_DUTY);
    assign w_wr_max  = w_wr_en & (r_addr == ADDR_MAX);
    assign w_err_clr = w_wr_en & (r_addr == ADDR_STAT);
    assign w_err_set = w_wr_en & addr_wr_illegal(r_addr);
    assign w_commit  = period_end & r_pending;

    // Shadows, atomic commit on period boundary, sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_sh   <= DUTY_RST;
            r_max_sh    <= MAX_RST;
            r_duty      <= DUTY_RST;
            r_max       <= MAX_RST;
            r_pending   <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_wr_duty) r_duty_sh <= w_byte;
            if (w_wr_max)  r_max_sh  <= w_byte;
            // Commit reads the pre-write shadows; a coincident write stays pending
            if (w_commit) begin
                r_duty <= r_duty_sh;
                r_max  <= r_max_sh;
            end
            r_cfg_valid <= w_commit;
            if (w_wr_duty || w_wr_max) r_pending <= 1'b1;
            else if (w_commit)         r_pending <= 1'b0;
            if (w_err_clr)      r_err <= 1'b0;
            else if (w_err_set) r_err <= 1'b1;
        end
    end

    assign spi.spi_miso = r_miso;
    assign duty         = r_duty;
    assign max_value    = r_max;
    assign cfg_valid    = r_cfg_valid;
    assign err          = r_err;

endmodule
